// File: rtl/instruction_package.sv
// ---------------------------------------------------------------------------
// instruction_package
// Shared definitions for the branching regex execution unit:
//   - OPCODE_WIDTH : width of the opcode field at the top of an instruction
//   - opcode_t     : 3-bit instruction opcodes
//   - state_t      : execution FSM states
// No ports (package).
// ---------------------------------------------------------------------------
package instruction_package;

  localparam int OPCODE_WIDTH = 3;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_ACCEPT      = 3'd0,
    OP_MATCH       = 3'd1,
    OP_NOT_MATCH   = 3'd2,
    OP_MATCH_ANY   = 3'd3,
    OP_JMP         = 3'd4,
    OP_SPLIT       = 3'd5,
    OP_MATCH_RANGE = 3'd6,
    OP_RESERVED    = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_SPLIT2 = 2'd3
  } state_t;

endpackage

// File: rtl/regex_cpu_out_fifo.sv
// ---------------------------------------------------------------------------
// regex_cpu_out_fifo
// Output thread FIFO of the regex execution unit. Entries are {pc, cc_id};
// the channel id sits in the low CC_ID_BITS bits of each entry.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push, push_data   write one entry (caller guarantees a free slot)
//   pop               remove the head entry (ignored when empty)
//   head, empty       current head entry and empty flag
//   free_slots        number of unused entries
//   ch_count[i]       number of stored entries belonging to channel i
// ---------------------------------------------------------------------------
module regex_cpu_out_fifo #(
  parameter int WIDTH      = 11,
  parameter int DEPTH_POW  = 2,
  parameter int CC_ID_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head,
  output logic                 empty,
  output logic [DEPTH_POW:0]   free_slots,
  output logic [DEPTH_POW:0]   ch_count [2**CC_ID_BITS]
);

  localparam int DEPTH = 2**DEPTH_POW;
  localparam int NCH   = 2**CC_ID_BITS;
  localparam logic [DEPTH_POW-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_POW:0]   CNT_ONE = 1;

  logic [WIDTH-1:0]      mem_reg [DEPTH];
  logic [DEPTH_POW-1:0]  wr_ptr_reg;
  logic [DEPTH_POW-1:0]  rd_ptr_reg;
  logic [DEPTH_POW:0]    count_reg;
  logic                  do_pop;
  logic [CC_ID_BITS-1:0] push_cc;
  logic [CC_ID_BITS-1:0] head_cc;

  assign empty      = (count_reg == '0);
  assign do_pop     = pop && !empty;
  assign head       = mem_reg[rd_ptr_reg];
  assign free_slots = (DEPTH_POW+1)'(DEPTH) - count_reg;
  assign push_cc    = push_data[CC_ID_BITS-1:0];
  assign head_cc    = head[CC_ID_BITS-1:0];

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Per-channel occupancy; a push and pop of the same channel cancel out.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [DEPTH_POW:0] cnt_reg;
    logic               inc;
    logic               dec;

    assign inc = push && (push_cc == CC_ID_BITS'(gi));
    assign dec = do_pop && (head_cc == CC_ID_BITS'(gi));
    assign ch_count[gi] = cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_reg <= '0;
      end else if (inc && !dec) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end else if (dec && !inc) begin
        cnt_reg <= cnt_reg - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/regex_cpu_branching.sv
// ---------------------------------------------------------------------------
// regex_cpu_branching
// Regex execution unit with branching: takes a (pc, cc_id) thread, fetches
// one instruction, evaluates it against the channel's current character and
// pushes zero, one (MATCH*, JMP) or two (SPLIT) successor threads into an
// output FIFO. ACCEPT at end of string pulses `accepts`.
// Optional feature: define REGEX_CPU_RANGE_MATCH_EN to enable MATCH_RANGE;
// otherwise opcode 6 drops the thread like the reserved opcode.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   current_characters, end_of_string per-channel character / end flag
//   input_pc_valid/ready, input_pc, input_cc_id     thread input
//   memory_valid, memory_addr, memory_ready, memory_data  program fetch
//   output_pc_valid/ready, output_pc, output_cc_id  thread output
//   accepts, accepts_cc_id           accept pulse and its channel
//   running, elaborating_chars       activity status
// ---------------------------------------------------------------------------
module regex_cpu_branching
  import instruction_package::*;
#(
  parameter int PC_WIDTH              = 9,
  parameter int CC_ID_BITS            = 2,
  parameter int CHARACTER_WIDTH       = 8,
  parameter int MEMORY_WIDTH          = 20,
  parameter int MEMORY_ADDR_WIDTH     = 11,
  parameter int FIFO_WIDTH_POWER_OF_2 = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0] current_characters,
  input  logic [2**CC_ID_BITS-1:0]                  end_of_string,
  input  logic                                      input_pc_valid,
  output logic                                      input_pc_ready,
  input  logic [PC_WIDTH-1:0]                       input_pc,
  input  logic [CC_ID_BITS-1:0]                     input_cc_id,
  output logic                                      memory_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]              memory_addr,
  input  logic                                      memory_ready,
  input  logic [MEMORY_WIDTH-1:0]                   memory_data,
  output logic                                      output_pc_valid,
  input  logic                                      output_pc_ready,
  output logic [PC_WIDTH-1:0]                       output_pc,
  output logic [CC_ID_BITS-1:0]                     output_cc_id,
  output logic                                      accepts,
  output logic [CC_ID_BITS-1:0]                     accepts_cc_id,
  output logic                                      running,
  output logic [2**CC_ID_BITS-1:0]                  elaborating_chars
);

  localparam int NCH         = 2**CC_ID_BITS;
  localparam int CW          = CHARACTER_WIDTH;
  localparam int DATA_WIDTH  = MEMORY_WIDTH - OPCODE_WIDTH;
  localparam int ENTRY_WIDTH = PC_WIDTH + CC_ID_BITS;
  localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

  if (MEMORY_ADDR_WIDTH < PC_WIDTH) begin : g_addr_check
    $error("MEMORY_ADDR_WIDTH must be >= PC_WIDTH");
  end
`ifdef REGEX_CPU_RANGE_MATCH_EN
  if (DATA_WIDTH < 2*CHARACTER_WIDTH) begin : g_range_check
    $error("range match needs MEMORY_WIDTH-3 >= 2*CHARACTER_WIDTH");
  end
`endif

  state_t                  state_reg, state_next;
  logic [PC_WIDTH-1:0]     pc_reg;
  logic [CC_ID_BITS-1:0]   cc_reg;
  logic [PC_WIDTH-1:0]     target_reg;
  logic                    accepts_reg;
  logic [CC_ID_BITS-1:0]   accepts_cc_reg;

  logic [CW-1:0]           chars [NCH];
  logic [CW-1:0]           cur_char;
  logic                    cur_eos;
  opcode_t                 opcode;
  logic [DATA_WIDTH-1:0]   data;
  logic [PC_WIDTH-1:0]     pc_inc;
  logic                    range_hit;
  logic                    push;
  logic [PC_WIDTH-1:0]     push_pc;
  logic                    accept_hit;

  logic [ENTRY_WIDTH-1:0]  fifo_head;
  logic                    fifo_empty;
  logic [FIFO_WIDTH_POWER_OF_2:0] free_slots;
  logic [FIFO_WIDTH_POWER_OF_2:0] ch_count [NCH];
  logic                    unused_data_bits;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chars
    assign chars[gi] = current_characters[gi*CW +: CW];
  end

  assign cur_char = chars[cc_reg];
  assign cur_eos  = end_of_string[cc_reg];
  assign opcode   = opcode_t'(memory_data[MEMORY_WIDTH-1 -: OPCODE_WIDTH]);
  assign data     = memory_data[DATA_WIDTH-1:0];
  assign pc_inc   = pc_reg + PC_ONE;
  assign unused_data_bits = ^data;

`ifdef REGEX_CPU_RANGE_MATCH_EN
  assign range_hit = (data[CW-1:0] <= cur_char) && (cur_char <= data[2*CW-1:CW]);
`else
  assign range_hit = 1'b0;
`endif

  // Two free slots are reserved before accepting a thread so a SPLIT can
  // always push both successors without checking FIFO space.
  assign input_pc_ready = (state_reg == ST_IDLE) &&
                          (free_slots >= (FIFO_WIDTH_POWER_OF_2+1)'(2));
  assign memory_valid   = (state_reg == ST_FETCH);
  assign memory_addr    = MEMORY_ADDR_WIDTH'(pc_reg);

  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    push_pc    = pc_inc;
    accept_hit = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (input_pc_valid && input_pc_ready) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (memory_ready) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = ST_IDLE;
        case (opcode)
          OP_ACCEPT:      accept_hit = cur_eos;
          OP_MATCH:       push = !cur_eos && (cur_char == data[CW-1:0]);
          OP_NOT_MATCH:   push = !cur_eos && (cur_char != data[CW-1:0]);
          OP_MATCH_ANY:   push = !cur_eos;
          OP_JMP: begin
            push    = 1'b1;
            push_pc = data[PC_WIDTH-1:0];
          end
          OP_SPLIT: begin
            push       = 1'b1;
            state_next = ST_SPLIT2;
          end
          OP_MATCH_RANGE: push = !cur_eos && range_hit;
          default:        push = 1'b0;
        endcase
      end
      ST_SPLIT2: begin
        push       = 1'b1;
        push_pc    = target_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      pc_reg         <= '0;
      cc_reg         <= '0;
      target_reg     <= '0;
      accepts_reg    <= 1'b0;
      accepts_cc_reg <= '0;
    end else begin
      state_reg   <= state_next;
      accepts_reg <= accept_hit;
      if (state_reg == ST_IDLE && input_pc_valid && input_pc_ready) begin
        pc_reg <= input_pc;
        cc_reg <= input_cc_id;
      end
      // memory_data is only valid during EXEC; keep the SPLIT target.
      if (state_reg == ST_EXEC) begin
        target_reg <= data[PC_WIDTH-1:0];
      end
      if (accept_hit) begin
        accepts_cc_reg <= cc_reg;
      end
    end
  end

  regex_cpu_out_fifo #(
    .WIDTH      (ENTRY_WIDTH),
    .DEPTH_POW  (FIFO_WIDTH_POWER_OF_2),
    .CC_ID_BITS (CC_ID_BITS)
  ) u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  ({push_pc, cc_reg}),
    .pop        (output_pc_ready),
    .head       (fifo_head),
    .empty      (fifo_empty),
    .free_slots (free_slots),
    .ch_count   (ch_count)
  );

  // Head is masked while empty so the output reads zero after reset.
  assign output_pc_valid = !fifo_empty;
  assign {output_pc, output_cc_id} = fifo_empty ? '0 : fifo_head;
  assign accepts         = accepts_reg;
  assign accepts_cc_id   = accepts_cc_reg;
  assign running         = (state_reg != ST_IDLE) || !fifo_empty;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_elab
    assign elaborating_chars[gi] =
      ((state_reg != ST_IDLE) && (cc_reg == CC_ID_BITS'(gi))) || (ch_count[gi] != '0);
  end

endmodule

// File: tb/tb_regex_cpu_branching.sv
module tb_regex_cpu_branching;
  localparam int PCW = 9;
  localparam int CCB = 2;
  localparam int CW  = 8;
  localparam int MW  = 20;
  localparam int MAW = 11;
  localparam int NCH = 4;
`ifdef REGEX_CPU_RANGE_MATCH_EN
  localparam int RANGE_EN = 1;
`else
  localparam int RANGE_EN = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH*CW-1:0] current_characters;
  logic [NCH-1:0]    end_of_string;
  logic              input_pc_valid;
  logic              input_pc_ready;
  logic [PCW-1:0]    input_pc;
  logic [CCB-1:0]    input_cc_id;
  logic              memory_valid;
  logic [MAW-1:0]    memory_addr;
  logic              memory_ready;
  logic [MW-1:0]     memory_data;
  logic              output_pc_valid;
  logic              output_pc_ready;
  logic [PCW-1:0]    output_pc;
  logic [CCB-1:0]    output_cc_id;
  logic              accepts;
  logic [CCB-1:0]    accepts_cc_id;
  logic              running;
  logic [NCH-1:0]    elaborating_chars;

  logic [MW-1:0]      prog [2**MAW];
  logic [PCW+CCB-1:0] out_q [$];
  logic [CCB-1:0]     acc_q [$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regex_cpu_branching dut (
    .clk                (clk),
    .rst                (rst),
    .current_characters (current_characters),
    .end_of_string      (end_of_string),
    .input_pc_valid     (input_pc_valid),
    .input_pc_ready     (input_pc_ready),
    .input_pc           (input_pc),
    .input_cc_id        (input_cc_id),
    .memory_valid       (memory_valid),
    .memory_addr        (memory_addr),
    .memory_ready       (memory_ready),
    .memory_data        (memory_data),
    .output_pc_valid    (output_pc_valid),
    .output_pc_ready    (output_pc_ready),
    .output_pc          (output_pc),
    .output_cc_id       (output_cc_id),
    .accepts            (accepts),
    .accepts_cc_id      (accepts_cc_id),
    .running            (running),
    .elaborating_chars  (elaborating_chars)
  );

  // Program memory: data returned the cycle after a grant.
  always @(posedge clk) begin
    if (memory_valid && memory_ready) memory_data <= prog[memory_addr];
  end

  // Transfer monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (output_pc_valid && output_pc_ready) out_q.push_back({output_pc, output_cc_id});
      if (accepts) acc_q.push_back(accepts_cc_id);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [MW-1:0] enc(input logic [2:0] op, input logic [16:0] d);
    return {op, d};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_char(input int ch, input logic [7:0] val);
    current_characters[ch*CW +: CW] = val;
  endtask

  task automatic send(input logic [PCW-1:0] pc, input logic [CCB-1:0] cc);
    int n;
    n = 0;
    input_pc = pc;
    input_cc_id = cc;
    input_pc_valid = 1'b1;
    while (!input_pc_ready && n < 40) begin
      tick(1);
      n++;
    end
    check_value("send_ready", 32'(n < 40), 1);
    tick(1);
    input_pc_valid = 1'b0;
  endtask

  task automatic run_case(input string tag, input logic [PCW-1:0] pc, input logic [CCB-1:0] cc,
                          input int exp_n, input logic [PCW-1:0] exp_pc, input int exp_acc);
    out_q.delete();
    acc_q.delete();
    send(pc, cc);
    tick(8);
    check_value({tag, "_nout"}, out_q.size(), exp_n);
    if (exp_n > 0 && out_q.size() > 0) check_value({tag, "_out"}, out_q[0], {exp_pc, cc});
    check_value({tag, "_nacc"}, acc_q.size(), exp_acc);
    if (exp_acc > 0 && acc_q.size() > 0) check_value({tag, "_acc_cc"}, acc_q[0], cc);
    check_value({tag, "_idle"}, {running, input_pc_ready}, 2'b01);
    $display("case %s: pc=%0d cc=%0d outputs=%0d accepts=%0d", tag, pc, cc, out_q.size(), acc_q.size());
  endtask

  initial begin
    logic [7:0] rchars [4];
    rchars = '{8'h61, 8'h6d, 8'h7a, 8'h7b};
    input_pc_valid = 1'b0;
    input_pc = '0;
    input_cc_id = '0;
    output_pc_ready = 1'b1;
    memory_ready = 1'b1;
    memory_data = '0;
    end_of_string = '0;
    current_characters = '0;
    for (int i = 0; i < 2**MAW; i++) prog[i] = enc(3'd7, 17'd0);
    prog[220] = enc(3'd1, 17'h41);                  // MATCH 'A'
    prog[511] = enc(3'd2, 17'h43);                  // NOT_MATCH 'C'
    prog[10]  = enc(3'd5, 17'd40);                  // SPLIT 40
    prog[30]  = enc(3'd0, 17'd0);                   // ACCEPT
    prog[50]  = enc(3'd6, {1'b0, 8'h7a, 8'h61});    // MATCH_RANGE 'a'..'z'
    prog[60]  = enc(3'd4, 17'd300);                 // JMP 300
    prog[70]  = enc(3'd7, 17'd0);                   // reserved
    prog[80]  = enc(3'd3, 17'd0);                   // MATCH_ANY

    tick(1);
    rst = 1'b0;
    tick(2);
    check_value("rst_in_ready", input_pc_ready, 1);
    check_value("rst_mem_valid", memory_valid, 0);
    check_value("rst_mem_addr", memory_addr, 0);
    check_value("rst_out_valid", output_pc_valid, 0);
    check_value("rst_out_pc", {output_pc, output_cc_id}, 0);
    check_value("rst_accepts", {accepts, accepts_cc_id}, 0);
    check_value("rst_status", {running, elaborating_chars}, 0);
    rst = 1'b1;
    tick(2);

    // MATCH hit with cycle-level timing.
    set_char(1, 8'h41);
    out_q.delete();
    send(9'd220, 2'd1);
    check_value("m_fetch_valid", memory_valid, 1);
    check_value("m_fetch_addr", memory_addr, 220);
    check_value("m_elab", elaborating_chars, 4'b0010);
    check_value("m_busy_ready", input_pc_ready, 0);
    tick(1);
    check_value("m_exec_no_out", output_pc_valid, 0);
    tick(1);
    check_value("m_out_valid", output_pc_valid, 1);
    check_value("m_out_pc", output_pc, 221);
    check_value("m_out_cc", output_cc_id, 1);
    tick(6);
    check_value("m_nout", out_q.size(), 1);
    check_value("m_idle", {running, input_pc_ready}, 2'b01);
    $display("case match_hit: outputs=%0d", out_q.size());

    set_char(1, 8'h42);
    run_case("match_miss", 9'd220, 2'd1, 0, 9'd0, 0);
    set_char(0, 8'h41);
    run_case("not_match_wrap", 9'd511, 2'd0, 1, 9'd0, 0);
    set_char(0, 8'h43);
    run_case("not_match_eq", 9'd511, 2'd0, 0, 9'd0, 0);
    run_case("match_any", 9'd80, 2'd2, 1, 9'd81, 0);
    end_of_string = 4'b0100;
    run_case("match_any_eos", 9'd80, 2'd2, 0, 9'd0, 0);
    run_case("accept_eos", 9'd30, 2'd2, 0, 9'd0, 1);
    end_of_string = 4'b0000;
    run_case("accept_no_eos", 9'd30, 2'd2, 0, 9'd0, 0);
    run_case("jmp", 9'd60, 2'd1, 1, 9'd300, 0);
    run_case("reserved", 9'd70, 2'd3, 0, 9'd0, 0);
    for (int i = 0; i < 4; i++) begin
      set_char(0, rchars[i]);
      run_case($sformatf("range_%0d", i), 9'd50, 2'd0, (i < 3) ? RANGE_EN : 0, 9'd51, 0);
    end

    // SPLIT with a stalled consumer: two splits fill the FIFO.
    out_q.delete();
    output_pc_ready = 1'b0;
    send(9'd10, 2'd3);
    tick(4);
    check_value("split1_ready", input_pc_ready, 1);
    check_value("split1_nout", out_q.size(), 0);
    send(9'd10, 2'd3);
    tick(4);
    check_value("split_full_ready", input_pc_ready, 0);
    check_value("split_elab", elaborating_chars, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      check_value("split_hold_valid", output_pc_valid, 1);
      check_value("split_hold_head", {output_pc, output_cc_id}, {9'd11, 2'd3});
      tick(1);
    end
    output_pc_ready = 1'b1;
    tick(8);
    check_value("split_nout", out_q.size(), 4);
    if (out_q.size() == 4) begin
      check_value("split_out0", out_q[0], {9'd11, 2'd3});
      check_value("split_out1", out_q[1], {9'd40, 2'd3});
      check_value("split_out2", out_q[2], {9'd11, 2'd3});
      check_value("split_out3", out_q[3], {9'd40, 2'd3});
    end
    check_value("split_idle", {running, input_pc_ready, elaborating_chars}, 6'b010000);
    $display("case split: outputs=%0d", out_q.size());

    // Reset while a fetch is stalled.
    memory_ready = 1'b0;
    set_char(1, 8'h41);
    send(9'd220, 2'd1);
    tick(2);
    check_value("rst_mid_fetch", {memory_valid, memory_addr}, {1'b1, 11'd220});
    rst = 1'b0;
    #1;
    check_value("rst_mid_mem", {memory_valid, memory_addr}, 0);
    check_value("rst_mid_status", {running, elaborating_chars, input_pc_ready}, 1);
    check_value("rst_mid_out", {output_pc_valid, output_pc, output_cc_id, accepts, accepts_cc_id}, 0);
    #2;
    rst = 1'b1;
    tick(1);
    memory_ready = 1'b1;
    run_case("after_reset", 9'd220, 2'd1, 1, 9'd221, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regex_cpu_branching.md
# regex_cpu_branching

Next-generation regex execution unit. It accepts a `(pc, cc_id)` thread, fetches one instruction from program memory, and evaluates it against that character channel's current character. Surviving threads are emitted through an internal output FIFO. Unlike the single-successor NOT_MATCH/MATCH unit, it supports branching (JMP, SPLIT with two successors), acceptance reporting and an optional range match, and it sits between the thread scheduler and program memory.

## Interface
Parameters:
- PC_WIDTH, 9: thread program-counter width.
- CC_ID_BITS, 2: character-channel id width; 2**CC_ID_BITS channels.
- CHARACTER_WIDTH, 8: bits per character.
- MEMORY_WIDTH, 20: instruction word; opcode in top 3 bits, data in remaining MEMORY_WIDTH-3 bits.
- MEMORY_ADDR_WIDTH, 11: program address width; must be >= PC_WIDTH; pc is zero-extended.
- FIFO_WIDTH_POWER_OF_2, 2: output FIFO depth = 2**FIFO_WIDTH_POWER_OF_2; minimum 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- current_characters  in  (2**CC_ID_BITS)*CHARACTER_WIDTH  character of channel i at slice i.
- end_of_string  in  2**CC_ID_BITS  channel i has consumed its string.
- input_pc_valid / input_pc_ready  in / out  1  thread-input handshake.
- input_pc  in  PC_WIDTH;  input_cc_id  in  CC_ID_BITS.
- memory_valid  out  1  fetch request;  memory_addr  out  MEMORY_ADDR_WIDTH.
- memory_ready  in  1  memory grants request;  memory_data  in  MEMORY_WIDTH  valid the cycle after grant.
- output_pc_valid / output_pc_ready  out / in  1  thread-output handshake.
- output_pc  out  PC_WIDTH;  output_cc_id  out  CC_ID_BITS.
- accepts  out  1  one-cycle pulse: a thread reached ACCEPT at end of string.
- accepts_cc_id  out  CC_ID_BITS  channel of that accept.
- running  out  1  FSM not IDLE or FIFO non-empty.
- elaborating_chars  out  2**CC_ID_BITS  bit i set while the FSM holds a channel-i thread or the FIFO holds >= 1 channel-i entry.

## Operation
- FSM states are IDLE, FETCH, EXEC and SPLIT2.
- **IDLE:** input_pc_ready = 1 only when IDLE and FIFO free slots >= 2. On handshake, latch pc and cc_id and go to FETCH.
- **FETCH:** memory_valid = 1 with memory_addr = pc, both held stable until memory_ready = 1, then go to EXEC.
- **EXEC** (memory_data sampled here). Let c = the channel's character and e = its end_of_string bit. Opcodes (instruction_package):
  - ACCEPT = 0: if e, pulse accepts; no output.
  - MATCH = 1: push pc+1 if !e and c == data[CW-1:0].
  - NOT_MATCH = 2: push pc+1 if !e and c != data[CW-1:0].
  - MATCH_ANY = 3: push pc+1 if !e.
  - JMP = 4: push data[PC_WIDTH-1:0].
  - SPLIT = 5: push pc+1, go to SPLIT2.
  - MATCH_RANGE = 6: see Configuration.
  - Opcode 7: reserved; the thread is dropped.
  - Every opcode except SPLIT returns to IDLE.
- **SPLIT2:** push data[PC_WIDTH-1:0], then return to IDLE.
- **Arithmetic:** pc+1 wraps modulo 2**PC_WIDTH; the output cc_id equals the input cc_id.
- **FIFO:** simultaneous push and pop is allowed at any fill level. Overflow is impossible because of the 2-slot reservation. Pop on empty is ignored.
- **Reset mid-operation:** the FSM returns to IDLE and the FIFO and per-channel counters are cleared. The in-flight thread is lost and a pending memory request is withdrawn.

## Timing
- Reset values: input_pc_ready = 1, memory_valid = 0, memory_addr = 0, output_pc_valid = 0, output_pc = 0, output_cc_id = 0, accepts = 0, accepts_cc_id = 0, running = 0, elaborating_chars = 0.
- Input handshake at cycle T → memory_valid high from T+1.
- Grant at cycle G → EXEC at G+1 → output_pc_valid at G+2 (registered FIFO head).
- With memory_ready tied high, input to output is 3 cycles. SPLIT's second entry appears 1 cycle after the first.
- accepts pulses for exactly the cycle after EXEC.
- Once asserted, output_pc, output_cc_id and output_pc_valid stay stable until output_pc_ready.
- elaborating_chars[cc_id] rises the cycle after input handshake.

## Configuration
- REGEX_CPU_RANGE_MATCH_EN defined: MATCH_RANGE pushes pc+1 if !e and data[CW-1:0] <= c <= data[2*CW-1:CW], unsigned. This requires MEMORY_WIDTH-3 >= 2*CHARACTER_WIDTH, checked by an elaboration-time assertion.
- REGEX_CPU_RANGE_MATCH_EN undefined: opcode 6 behaves as reserved (thread dropped) and no comparators are built.

## Structure
- instruction_package: opcode enum (3-bit) and an opcode-field width constant.
- Sub-module regex_cpu_out_fifo, parametrised by width (PC_WIDTH+CC_ID_BITS) and depth. It exposes free-slot count, empty and head, plus per-channel occupancy counters of width FIFO_WIDTH_POWER_OF_2+1 used to build elaborating_chars.

## Test plan
- **MATCH 'A' at pc 220, cc 1, char 'A', eos 0** → one output (221, 1); char 'B' → no output, running drops, ready returns.
- **NOT_MATCH 'C' at pc 511, char 'A'** → output pc 0 (wrap), same cc_id; char 'C' → no output.
- **SPLIT target 40 at pc 10, cc 3, output_pc_ready low 5 cycles** → FIFO holds (11, 3) then (40, 3). input_pc_ready = 0 once fewer than 2 slots are free. Both outputs drain in order when ready rises.
- **ACCEPT with eos[2] = 1, cc 2** → accepts pulses 1 cycle with accepts_cc_id = 2 and no output. With eos = 0: no pulse, no output.
- **MATCH_RANGE lo = 'a', hi = 'z'; chars 'a', 'm', 'z', '{'** → outputs for the first three only when the macro is defined; none at all when undefined.
- **Assert rst low during FETCH with memory_ready held low** → memory_valid = 0 and all outputs at reset values immediately. After release, a new MATCH completes normally.
